// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: feeds a 3-row sliding window of an image to a 3x3 conv layer and hands result rows downstream
//   clk/reset        : rising-edge clock, asynchronous active-low reset
//   start            : begin a frame (sampled only while idle)
//   row_valid/row_ready/row_data         : upstream row stream, pixel 0 in the MSBs
//   image_valid/image0..2                : window to the conv layer (image0 oldest); image_valid low holds conv units in reset
//   conv_o_valid/conv_out                : conv layer result strobe and row
//   out_valid/out_ready/out_data/out_row : captured result row handed downstream
//   busy/frame_done/timeout_err          : status; timeout_err only live with CONV_SCHED_TIMEOUT_EN defined
module conv_row_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int D          = 1,
  parameter int H          = 6,
  parameter int W          = 6,
  parameter int F          = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            row_valid,
  input  logic [W*DATA_WIDTH-1:0]         row_data,
  output logic                            row_ready,
  output logic                            image_valid,
  output logic [W*DATA_WIDTH-1:0]         image0,
  output logic [W*DATA_WIDTH-1:0]         image1,
  output logic [W*DATA_WIDTH-1:0]         image2,
  input  logic                            conv_o_valid,
  input  logic [(W-F+1)*DATA_WIDTH-1:0]   conv_out,
  output logic                            out_valid,
  output logic [(W-F+1)*DATA_WIDTH-1:0]   out_data,
  input  logic                            out_ready,
  output logic [7:0]                      out_row,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            timeout_err
);
  localparam int RW  = W * DATA_WIDTH;
  localparam int OWW = (W - F + 1) * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, CONV, OUT} state_t;
  state_t           state_q;
  logic [1:0]       need_q;
  logic             row_ready_q, image_valid_q, out_valid_q, busy_q, frame_done_q;
  logic [RW-1:0]    img0_q, img1_q, img2_q;
  logic [OWW-1:0]   out_data_q;
  logic [7:0]       out_row_q;
  logic             last_row_d;
  assign last_row_d = out_row_q == 8'(H - F);
`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int TMO_LIMIT = D * F * F + 8;
  localparam int TW = $clog2(TMO_LIMIT);
  logic [TW-1:0] tmo_q;
  logic          timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  logic unused_depth;
  assign unused_depth = D > 0;
  assign timeout_err  = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      need_q        <= '0;
      row_ready_q   <= 1'b0;
      image_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      img0_q        <= '0;
      img1_q        <= '0;
      img2_q        <= '0;
      out_data_q    <= '0;
      out_row_q     <= '0;
`ifdef CONV_SCHED_TIMEOUT_EN
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q     <= FILL;
          need_q      <= 2'd3;
          out_row_q   <= '0;
          row_ready_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        FILL: if (row_valid && row_ready_q) begin
          img0_q <= img1_q;
          img1_q <= img2_q;
          img2_q <= row_data;
          need_q <= need_q - 2'd1;
          if (need_q == 2'd1) begin
            state_q       <= CONV;
            row_ready_q   <= 1'b0;
            image_valid_q <= 1'b1;
`ifdef CONV_SCHED_TIMEOUT_EN
            tmo_q         <= '0;
`endif
          end
        end
        CONV: if (conv_o_valid) begin
          out_data_q    <= conv_out;
          out_valid_q   <= 1'b1;
          image_valid_q <= 1'b0;
          state_q       <= OUT;
        end
`ifdef CONV_SCHED_TIMEOUT_EN
        else if (tmo_q == TW'(TMO_LIMIT - 1)) begin
          timeout_err_q <= 1'b1;
          image_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end else tmo_q <= tmo_q + 1'b1;
`endif
        // out_valid is always high in OUT, so out_ready alone completes the handshake
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          if (last_row_d) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            out_row_q   <= out_row_q + 8'd1;
            need_q      <= 2'd1;
            row_ready_q <= 1'b1;
            state_q     <= FILL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign row_ready   = row_ready_q;
  assign image_valid = image_valid_q;
  assign image0      = img0_q;
  assign image1      = img1_q;
  assign image2      = img2_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler: self-checking bench for conv_row_scheduler
module tb_conv_row_scheduler;
  localparam int DW = 8, D = 1, H = 6, W = 6, F = 3;
  localparam int OW = W - F + 1, RW = W * DW, OWW = OW * DW;
  logic clk = 0, reset = 0, start = 0, row_valid = 0, conv_o_valid = 0, out_ready = 1;
  logic [RW-1:0] row_data = '0;
  logic [OWW-1:0] conv_out = '0;
  logic row_ready, image_valid, out_valid, busy, frame_done, timeout_err;
  logic [RW-1:0] image0, image1, image2;
  logic [OWW-1:0] out_data;
  logic [7:0] out_row;
  always #5 clk = ~clk;
  conv_row_scheduler #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .F(F)) dut (
    .clk(clk), .reset(reset), .start(start), .row_valid(row_valid), .row_data(row_data),
    .row_ready(row_ready), .image_valid(image_valid), .image0(image0), .image1(image1),
    .image2(image2), .conv_o_valid(conv_o_valid), .conv_out(conv_out), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .out_row(out_row), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err));
  int checks = 0, errors = 0;
  logic [7:0] pix [H][W];
  int rows_sent = 0, res_idx = 0, fd_cnt = 0;
  bit feeding = 0, conv_en = 1;
  int stall_at = -1, stall_len = 0, stall_cnt = 0, bp_row = -1, bp_len = 0, bp_cnt = 0;
  logic [OWW-1:0] got [H-F+1];
  logic [RW-1:0] win0 [H-F+1], win2 [H-F+1];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [RW-1:0] pack(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < W; c++) v[(W-1-c)*DW +: DW] = pix[r][c];
    return v;
  endfunction
  function automatic logic [OWW-1:0] exp_out(input int k);
    logic [OWW-1:0] e;
    for (int j = 0; j < OW; j++) e[(OW-1-j)*DW +: DW] = pix[k][j] + pix[k+1][j] + pix[k+2][j];
    return e;
  endfunction
  function automatic logic [OWW-1:0] conv_fn(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [RW-1:0] c);
    logic [OWW-1:0] r;
    for (int j = 0; j < OW; j++) r[(OW-1-j)*DW +: DW] = a[(W-1-j)*DW +: DW] + b[(W-1-j)*DW +: DW] + c[(W-1-j)*DW +: DW];
    return r;
  endfunction
  // upstream row source
  initial forever begin
    @(negedge clk); #1;
    if (start && !busy) begin rows_sent = 0; stall_cnt = 0; end
    if (feeding && rows_sent < H && rows_sent == stall_at && stall_cnt < stall_len) begin
      row_valid = 0;
      stall_cnt++;
      chk("stall_fill", {row_ready, image_valid, busy}, 3'b101);
    end else if (feeding && rows_sent < H) begin
      row_valid = 1;
      row_data = pack(rows_sent);
    end else row_valid = 0;
    if (row_valid && row_ready) rows_sent++;
  end
  // conv layer stub: strobes D*F*F+2 cycles after image_valid rises
  initial begin
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk); #1;
      if (image_valid && !prev && conv_en) begin
        repeat (D*F*F+1) @(negedge clk);
        #1;
        conv_out = conv_fn(image0, image1, image2);
        conv_o_valid = 1;
        @(negedge clk); #1;
        conv_o_valid = 0;
      end
      prev = image_valid;
    end
  end
  // compare process and downstream sink
  initial forever begin
    @(negedge clk); #1;
    if (start && !busy) begin res_idx = 0; bp_cnt = 0; end
    if (busy) begin
      chk("iv_rr_excl", image_valid && row_ready, 0);
      chk("iv_ov_excl", image_valid && out_valid, 0);
    end
    if (image_valid) begin
      if (res_idx > H-F) chk("win_idx", res_idx, H-F);
      else begin
        chk("image0", image0, pack(res_idx));
        chk("image1", image1, pack(res_idx+1));
        chk("image2", image2, pack(res_idx+2));
        win0[res_idx] = image0;
        win2[res_idx] = image2;
      end
    end
    if (out_valid) begin
      if (res_idx > H-F) chk("out_idx", res_idx, H-F);
      else begin
        chk("out_row", out_row, res_idx);
        chk("out_data", out_data, exp_out(res_idx));
        got[res_idx] = out_data;
      end
    end
    if (out_valid && res_idx == bp_row && bp_cnt < bp_len) begin
      out_ready = 0;
      bp_cnt++;
      chk("bp_hold", {row_ready, image_valid}, 2'b00);
    end else out_ready = 1;
    if (out_valid && out_ready) res_idx++;
    if (frame_done) begin
      fd_cnt++;
      chk("fd_rows", rows_sent, H);
      chk("fd_results", res_idx, H-F+1);
      chk("fd_idle", busy, 0);
    end
  end
  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask
  task automatic wait_fd(input int budget);
    int base;
    bit ok;
    base = fd_cnt;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (fd_cnt > base) ok = 1;
    end
    chk("frame_done_seen", ok, 1);
  endtask
  task automatic wait_iv(input int budget, input int idx);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (image_valid && res_idx == idx) ok = 1;
    end
    chk("window_seen", ok, 1);
  endtask
  task automatic run_frame();
    feeding = 1;
    pulse_start();
    wait_fd(400);
    feeding = 0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    #3;
    chk("rst_ctrl", {row_ready, image_valid, out_valid, frame_done, busy, timeout_err}, 6'b0);
    chk("rst_row", out_row, 0);
    chk("rst_img", image0 | image1 | image2, 0);
    chk("rst_out", out_data, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    // frame 1: constant rows 1..6
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 8'(r + 1);
    run_frame();
    chk("f1_res0", got[0], 32'h06060606);
    chk("f1_res3", got[3], 32'h0f0f0f0f);
    chk("f1_win0", win0[1], {6{8'h02}});
    chk("f1_win2", win2[1], {6{8'h04}});
    chk("f1_fd_cnt", fd_cnt, 1);
    chk("f1_idle", {busy, row_ready, image_valid}, 3'b000);
    // frame 2: downstream backpressure on result row 1
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 8'(r*37 + c*11 + 5);
    bp_row = 1; bp_len = 5;
    run_frame();
    bp_row = -1;
    chk("bp_cycles", bp_cnt, 5);
    chk("f2_res1", got[1], 32'hED0E2F50);
    chk("f2_fd_cnt", fd_cnt, 2);
    // frame 3: upstream stall in FILL and a start pulse while busy
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 8'($urandom);
    stall_at = 1; stall_len = 4;
    feeding = 1;
    pulse_start();
    wait_iv(200, 1);
    pulse_start();
    wait_fd(400);
    feeding = 0;
    repeat (3) @(negedge clk);
    stall_at = -1;
    chk("stall_cycles", stall_cnt, 4);
    chk("f3_fd_cnt", fd_cnt, 3);
    // frame 4: reset during CONV of row 2, then a fresh frame
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 8'($urandom);
    feeding = 1;
    pulse_start();
    wait_iv(300, 2);
    #3 reset = 0;
    #1;
    chk("mr_ctrl", {row_ready, image_valid, out_valid, frame_done, busy, timeout_err}, 6'b0);
    chk("mr_row", out_row, 0);
    chk("mr_img", image0 | image1 | image2, 0);
    chk("mr_out", out_data, 0);
    feeding = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (20) @(negedge clk);
    chk("mr_idle", {busy, image_valid, out_valid, row_ready}, 4'b0);
    chk("mr_no_fd", fd_cnt, 3);
    run_frame();
    chk("f5_res0", got[0], exp_out(0));
    chk("f5_fd_cnt", fd_cnt, 4);
    // conv layer never answers
    conv_en = 0;
    feeding = 1;
    pulse_start();
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (image_valid) ok = 1;
      end
      chk("tmo_conv_seen", ok, 1);
    end
`ifdef CONV_SCHED_TIMEOUT_EN
    repeat (D*F*F+7) @(negedge clk);
    chk("tmo_early", {timeout_err, busy, image_valid}, 3'b011);
    @(negedge clk);
    chk("tmo_fire", {timeout_err, busy, image_valid}, 3'b100);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", timeout_err, 1);
`else
    repeat (30) @(negedge clk);
    chk("no_tmo_wait", {timeout_err, busy, image_valid}, 3'b011);
`endif
    chk("tmo_no_fd", fd_cnt, 4);
    feeding = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    conv_en = 1;
    @(negedge clk);
    chk("tmo_cleared", {timeout_err, busy}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_row_scheduler.md
CONV_ROW_SCHEDULER -- requirements
Module: conv_row_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 8, pixel width.
- D, 1, filter depth.
- H, 6, image height in rows.
- W, 6, image width in pixels.
- F, 3, filter size; only 3 is legal.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-low.
- start, in, 1, begin a frame; sampled only in IDLE.
- row_valid, in, 1, upstream row offered.
- row_data, in, W*DATA_WIDTH, one image row, pixel 0 in the MSBs.
- row_ready, out, 1, scheduler accepts a row.
- image_valid, out, 1, window valid to conv layer; also releases the conv units from reset.
- image0, out, W*DATA_WIDTH, oldest buffered row.
- image1, out, W*DATA_WIDTH, middle buffered row.
- image2, out, W*DATA_WIDTH, newest buffered row.
- conv_o_valid, in, 1, conv layer result strobe.
- conv_out, in, (W-F+1)*DATA_WIDTH, conv layer result row.
- out_valid, out, 1, result row held for downstream.
- out_data, out, (W-F+1)*DATA_WIDTH, captured result row.
- out_ready, in, 1, downstream accepts.
- out_row, out, 8, index of the row in out_data, 0..H-F.
- busy, out, 1, high whenever state is not IDLE.
- frame_done, out, 1, one-cycle pulse after the last row is handed off.
- timeout_err, out, 1, sticky conv-timeout flag.

Function
REQ-003 FSM SHALL have states IDLE, FILL, CONV, OUT; all outputs registered.
REQ-004 IDLE: row_ready=0, image_valid=0; start=1 -> FILL with need=3 and out_row=0.
REQ-005 FILL: row_ready=1; on row_valid&&row_ready SHALL shift image0<=image1, image1<=image2, image2<=row_data and decrement need; the accept that brings need to 0 SHALL move to CONV on the next edge.
REQ-006 CONV: image_valid SHALL be 1 starting the first cycle in CONV; image0..2 SHALL stay stable for the whole state.
REQ-007 In CONV, conv_o_valid=1 SHALL capture conv_out into out_data, set out_valid=1, clear image_valid and move to OUT on the same edge.
REQ-008 OUT: image_valid=0 (resets the conv units between rows); out_valid and out_data SHALL hold until out_valid&&out_ready.
REQ-009 On that handshake with out_row<H-F: clear out_valid, increment out_row, move to FILL with need=1 (sliding window).
REQ-010 On that handshake with out_row==H-F: clear out_valid, pulse frame_done for exactly one cycle, return to IDLE.
REQ-011 The conv layer SHALL assert conv_o_valid D*F*F+2 cycles after image_valid rises; the scheduler SHALL NOT rely on this count except under REQ-016.
REQ-012 Boundary conditions:
- start outside IDLE SHALL be ignored.
- conv_o_valid outside CONV SHALL be ignored.
- row_valid outside FILL SHALL see row_ready=0 and SHALL NOT be consumed.
- out_ready while out_valid=0 SHALL have no effect.
REQ-013 Rows consumed per frame SHALL equal H; result rows per frame SHALL equal H-F+1.

Reset
REQ-014 reset low SHALL asynchronously force the following, with the effect visible immediately:
- state=IDLE, need=0;
- row_ready, image_valid, out_valid, frame_done and busy = 0;
- out_row=0, timeout_err=0;
- image0..2 and out_data = all zeros.
REQ-015 reset asserted mid-frame SHALL abandon the frame; no frame_done is produced, and the next frame requires a new start.

Configuration
REQ-016 With macro CONV_SCHED_TIMEOUT_EN defined:
- a counter SHALL run in CONV;
- reaching D*F*F+8 cycles without conv_o_valid SHALL set timeout_err (sticky until reset), clear image_valid and return to IDLE with no frame_done.
REQ-017 Without CONV_SCHED_TIMEOUT_EN: no counter; CONV SHALL wait indefinitely; timeout_err SHALL be tied to 0.

Verification
REQ-018 Nominal frame (H=6, W=6): start, 6 rows with row_valid always high, conv model strobing 11 cycles after image_valid, out_ready=1 -> 4 results with out_row 0,1,2,3, then one frame_done pulse.
REQ-019 Window order: rows filled with constants 1..6 -> for out_row=k, image0/1/2 = k+1, k+2, k+3 in every pixel.
REQ-020 Backpressure: out_ready=0 for 5 cycles on row 1 -> out_data stable, row_ready=0, image_valid=0 throughout; resumes on out_ready=1.
REQ-021 Stalled upstream: row_valid drops for 4 cycles in FILL -> state stays FILL, image_valid=0, no row lost.
REQ-022 Mid-frame reset: reset low during CONV of row 2 -> all outputs at reset values immediately; a fresh start produces out_row=0 first.
REQ-023 Timeout (macro defined): conv_o_valid never asserted -> timeout_err=1 at CONV cycle 17, state IDLE, busy=0; macro undefined -> stays in CONV, timeout_err=0.
